// File: rtl/io_hex_display_if.sv
// Output-port bundle between the CPU-side writer and the hex display driver.
// The master drives the port word and controls, the display drives the pins.
interface io_hex_display_if;
  logic [31:0] out_port0;
  logic        update;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  modport master (output out_port0, update, blank_lz,
                  input  an, seg, frame_done);
  modport slave  (input  out_port0, update, blank_lz,
                  output an, seg, frame_done);
endinterface

// File: rtl/io_hex_display.sv
// Time-multiplexed common-anode 8-digit hex display driver for the CPU output port.
// Frames are latched from a shadow register only at frame wrap, so a digit never tears.
module io_hex_display #(
  parameter int CLK_DIV = 50000,
  parameter int DIGITS  = 8
) (
  input  logic            clock,
  input  logic            clrn,
  io_hex_display_if.slave io
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   frame_q, frame_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          fd_q, fd_d;

  logic          tick, last;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    hi_zero;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // hi_zero[i]: every scanned nibble from i upward is zero in the latched frame
  for (genvar i = 0; i < 8; i++) begin : g_lz
    if (i < DIGITS) begin : g_on
      assign hi_zero[i] = (frame_q[4*DIGITS-1:4*i] == '0);
    end else begin : g_off
      assign hi_zero[i] = 1'b1;
    end
  end

  assign tick  = (presc_q == PW'(CLK_DIV - 1));
  assign last  = (idx_q == 3'(DIGITS - 1));
  assign nib   = frame_q[{idx_q, 2'b00} +: 4];
  assign blank = io.blank_lz && (idx_q != 3'd0) && hi_zero[idx_q];

  always_comb begin
    shadow_d = io.update ? io.out_port0 : shadow_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    frame_d  = frame_q;
    fd_d     = 1'b0;
    if (tick) begin
      idx_d = last ? 3'd0 : idx_q + 3'd1;
      if (last) begin
        frame_d = shadow_q;
        fd_d    = 1'b1;
      end
    end
    // idx < DIGITS, so anode bits at or above DIGITS stay high here
    an_d  = blank ? 8'hFF : ~(8'd1 << idx_q);
    seg_d = blank ? 7'h7F : hex7(nib);
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      fd_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fd_q     <= fd_d;
    end
  end

  assign io.an         = an_q;
  assign io.seg        = seg_q;
  assign io.frame_done = fd_q;

endmodule

// File: tb/tb_io_hex_display.sv
// Directed bench: main display (CLK_DIV=4, DIGITS=8) plus a fast 4-digit corner instance.
module tb_io_hex_display;
  logic clock = 1'b0;
  logic clrn  = 1'b0;
  int   vecs = 0, errs = 0;
  int   n = 0;
  int   fd_cnt = 0;

  io_hex_display_if io_a ();
  io_hex_display_if io_b ();

  io_hex_display #(.CLK_DIV(4), .DIGITS(8)) dut_a (.clock(clock), .clrn(clrn), .io(io_a));
  io_hex_display #(.CLK_DIV(1), .DIGITS(4)) dut_b (.clock(clock), .clrn(clrn), .io(io_b));

  always #5 clock = ~clock;

  function automatic logic [6:0] dec(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] r;
    r = ~(8'd1 << d);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s n=%0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  // advance to the sample point after edge 'target' counted from reset release
  task automatic adv_to(input int target);
    while (n < target) begin
      @(negedge clock);
      n++;
      if (io_a.frame_done === 1'b1) fd_cnt++;
    end
  endtask

  initial begin
    logic [31:0] v;
    io_a.out_port0 = '0; io_a.update = 1'b0; io_a.blank_lz = 1'b0;
    io_b.out_port0 = '0; io_b.update = 1'b0; io_b.blank_lz = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_an",  io_a.an, 8'hFF);
    chk("rst_seg", io_a.seg, 7'h7F);
    chk("rst_fd",  io_a.frame_done, 1'b0);
    chk("rst_b_an", io_b.an, 8'hFF);
    clrn = 1'b1;
    n = 0;

    adv_to(20);
    chk("scan20_an",  io_a.an, 8'hEF);
    chk("scan20_seg", io_a.seg, 7'h40);

    // asynchronous reset between edges
    #2 clrn = 1'b0;
    #1;
    chk("midrst_an",  io_a.an, 8'hFF);
    chk("midrst_seg", io_a.seg, 7'h7F);
    chk("midrst_fd",  io_a.frame_done, 1'b0);
    chk("midrst_b_an", io_b.an, 8'hFF);
    #1 clrn = 1'b1;
    n = 0; fd_cnt = 0;

    adv_to(1);
    chk("rel_an",  io_a.an, 8'hFE);
    chk("rel_seg", io_a.seg, 7'h40);
    io_a.update = 1'b1; io_a.out_port0 = 32'h12345678;

    // corner instance: one digit per cycle, wrap every 4
    for (int k = 1; k <= 8; k++) begin
      adv_to(k);
      chk("b_an", io_b.an, an_of((k - 1) % 4));
      chk("b_fd", io_b.frame_done, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k == 2) io_a.update = 1'b0;
      if (k == 8) begin io_b.update = 1'b1; io_b.out_port0 = 32'hFFFFDCBA; end
    end
    adv_to(9);
    io_b.update = 1'b0;
    adv_to(13); chk("b_d0", io_b.an, 8'hFE); chk("b_s0", io_b.seg, 7'h08);
    adv_to(14); chk("b_d1", io_b.an, 8'hFD); chk("b_s1", io_b.seg, 7'h03);
    adv_to(15); chk("b_d2", io_b.an, 8'hFB); chk("b_s2", io_b.seg, 7'h46);
    adv_to(16); chk("b_d3", io_b.an, 8'hF7); chk("b_s3", io_b.seg, 7'h21);

    // basic display of 0x12345678
    adv_to(31); chk("fd31", io_a.frame_done, 1'b0);
    adv_to(32); chk("fd32", io_a.frame_done, 1'b1);
    chk("fdcnt32", fd_cnt, 1);
    v = 32'h12345678;
    for (int d = 0; d < 8; d++) begin
      adv_to(33 + 4*d);
      if (d == 2) io_a.update = 1'b0;
      chk("f1_an_first",  io_a.an, an_of(d));
      chk("f1_seg_first", io_a.seg, dec(v[4*d +: 4]));
      adv_to(36 + 4*d);
      chk("f1_an_last",  io_a.an, an_of(d));
      chk("f1_seg_last", io_a.seg, dec(v[4*d +: 4]));
      if (d == 1) begin io_a.update = 1'b1; io_a.out_port0 = 32'h0; end
    end

    // tear-free: load all-F at idx 3 of a zero frame
    adv_to(65); chk("f2_an0", io_a.an, 8'hFE); chk("f2_seg0", io_a.seg, 7'h40);
    adv_to(77); io_a.update = 1'b1; io_a.out_port0 = 32'hFFFFFFFF;
    adv_to(78); io_a.update = 1'b0;
    for (int d = 3; d < 8; d++) begin
      adv_to(68 + 4*d);
      chk("f2_an_hold",  io_a.an, an_of(d));
      chk("f2_seg_hold", io_a.seg, 7'h40);
    end
    chk("fd96", io_a.frame_done, 1'b1);
    chk("fdcnt96", fd_cnt, 3);
    for (int d = 0; d < 8; d++) begin
      adv_to(97 + 4*d);
      chk("f3_an",  io_a.an, an_of(d));
      chk("f3_seg", io_a.seg, 7'h0E);
    end

    // update coincident with wrap tick
    adv_to(127); io_a.update = 1'b1; io_a.out_port0 = 32'hAAAAAAAA;
    adv_to(128); io_a.update = 1'b0;
    chk("fd128", io_a.frame_done, 1'b1);
    chk("fdcnt128", fd_cnt, 4);
    adv_to(129); chk("f4_an0", io_a.an, 8'hFE); chk("f4_seg0", io_a.seg, 7'h0E);
    adv_to(160); chk("f4_an7", io_a.an, 8'h7F); chk("f4_seg7", io_a.seg, 7'h0E);
    adv_to(161); chk("f5_an0", io_a.an, 8'hFE); chk("f5_seg0", io_a.seg, 7'h08);

    // leading-zero blanking
    adv_to(170); io_a.update = 1'b1; io_a.out_port0 = 32'h000000A5; io_a.blank_lz = 1'b1;
    adv_to(171); io_a.update = 1'b0;
    adv_to(192); chk("f5_an7", io_a.an, 8'h7F); chk("f5_seg7", io_a.seg, 7'h08);
    adv_to(193); chk("bl_an0", io_a.an, 8'hFE); chk("bl_seg0", io_a.seg, 7'h12);
    adv_to(197); chk("bl_an1", io_a.an, 8'hFD); chk("bl_seg1", io_a.seg, 7'h08);
    adv_to(200); io_a.update = 1'b1; io_a.out_port0 = 32'h0;
    adv_to(201); io_a.update = 1'b0;
    chk("bl_an2", io_a.an, 8'hFF); chk("bl_seg2", io_a.seg, 7'h7F);
    adv_to(224); chk("bl_an7", io_a.an, 8'hFF); chk("bl_seg7", io_a.seg, 7'h7F);
    adv_to(225); chk("z_an0", io_a.an, 8'hFE); chk("z_seg0", io_a.seg, 7'h40);
    adv_to(229); chk("z_an1", io_a.an, 8'hFF); chk("z_seg1", io_a.seg, 7'h7F);
    adv_to(236); io_a.blank_lz = 1'b0;
    adv_to(237); chk("nz_an3", io_a.an, 8'hF7); chk("nz_seg3", io_a.seg, 7'h40);
    adv_to(253); chk("nz_an7", io_a.an, 8'h7F); chk("nz_seg7", io_a.seg, 7'h40);
    chk("fdcnt253", fd_cnt, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/io_hex_display.md
Name: io_hex_display

Overview:
- Reader/consumer side of the CPU's memory-mapped output port: takes the 32-bit `out_port0` word written by the pipelined computer's MEM stage.
- Drives an 8-digit, time-multiplexed, common-anode seven-segment display in hex.
- Provides tear-free frame latching, a programmable scan rate, optional leading-zero blanking and a frame-done strobe.
- Sits at board top level between the pipeline computer and the display pins.

Parameters:
- CLK_DIV, 50000, clock cycles each digit stays lit; legal range 1..2^20.
- DIGITS, 8, number of digits scanned; legal range 1..8. Digit i shows nibble `out_port0[4i+3:4i]`.

Ports:
- clock  input  1  system clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- out_port0  input  32  value written by the CPU to the output port.
- update  input  1  load strobe; `out_port0` is captured when high.
- blank_lz  input  1  1 = blank leading zero digits.
- an  output  8  digit enables, active-low. Bits at index ≥ DIGITS are held 1.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (clrn=0, asynchronous, any time including mid-frame):
  - shadow=0, frame_reg=0, prescaler=0, idx=0.
  - an=8'hFF, seg=7'h7F, frame_done=0.
- Shadow register: on a clock edge with update=1, shadow <= out_port0. Otherwise it holds.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick=1 in the cycle where prescaler==CLK_DIV-1.
  - With CLK_DIV=1, tick=1 every cycle.
- Digit index:
  - On tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Frame reload:
  - On a tick with idx==DIGITS-1: frame_reg <= shadow and frame_done <= 1.
  - All other cycles: frame_done <= 0.
  - If update=1 in the same cycle, the pre-edge shadow is loaded; the new value appears in the next frame.
  - The displayed value never changes mid-frame.
- Outputs are registered and computed from the current idx and frame_reg, so they lag idx by one cycle.
  - After reset release, the first edge gives an=~(1<<0) and seg showing nibble 0 of frame_reg.
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking:
  - Digit i (i>0) is blank when blank_lz=1 and nibbles i..DIGITS-1 of frame_reg are all zero.
  - A blank digit gives an=8'hFF and seg=7'h7F for its slot.
  - Digit 0 is never blanked.
  - blank_lz is sampled live each cycle and is not latched per frame.
- Exactly one `an` bit is low at any time, except for blank slots and during reset.
- No combinational path from any input to any output.

Test Plan (CLK_DIV=4, DIGITS=8 unless noted):
1. Reset mid-scan:
   - Stimulus: run 20 cycles, pulse clrn low between clock edges.
   - Response: an=FF, seg=7F, frame_done=0 immediately. After release, an=FE and seg=1000000 on the first edge.
2. Basic display:
   - Stimulus: update=1 for one cycle with 0x12345678, wait for frame wrap.
   - Response: next frame shows an=FE with seg=0000000 ('8'), then an=FD with seg=1111000 ('7'), …, then an=7F with seg=1111001 ('1'). Each slot lasts 4 cycles.
3. Tear-free latch:
   - Stimulus: load 0xFFFFFFFF at idx=3 of a frame displaying 0x00000000.
   - Response: digits 3..7 of the current frame still show '0'. 'F' appears from the next frame. frame_done is high exactly once per 32 cycles.
4. Update coincident with wrap:
   - Stimulus: assert update with 0xAAAAAAAA in the tick cycle where idx=7.
   - Response: the following frame still shows the old value; 'A' (0001000) appears one frame later.
5. Blanking:
   - Stimulus: blank_lz=1 with 0x000000A5.
   - Response: slots 2..7 give an=FF; slot 1 shows 'A', slot 0 shows '5'.
   - Stimulus: value 0x00000000.
   - Response: only slot 0 lit, showing '0'. With blank_lz=0, all 8 digits show '0'.
6. Parameter corners:
   - Stimulus: CLK_DIV=1, DIGITS=4.
   - Response: an cycles FE→FD→FB→F7→FE on consecutive cycles. an[7:4] stay 1. frame_done pulses every 4 cycles.
